// File: rtl/de_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | de_stage : decode/issue stage with register scoreboard and fetch stall   |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module de_stage #(
    parameter int XLEN = 32,
    parameter int NREG = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] fe_pc,
    input  logic [31:0]     fe_isn,
    output logic [1:0]      ctr,
    input  logic            ex_ready,
    input  logic            wb_valid,
    input  logic [4:0]      wb_rd,
    output logic            iss_valid,
    output logic [XLEN-1:0] iss_pc,
    output logic [5:0]      iss_op,
    output logic [4:0]      iss_rs,
    output logic [4:0]      iss_rt,
    output logic [4:0]      iss_dst,
    output logic            iss_wen,
    output logic [XLEN-1:0] iss_imm,
    output logic            iss_illegal,
    output logic [31:0]     stall_cnt
);

    localparam logic [1:0] c_CTR_RUN    = 2'b00;
    localparam logic [1:0] c_CTR_STALL  = 2'b10;
    localparam logic [5:0] c_OP_RTYPE   = 6'h00;
    localparam logic [5:0] c_OP_J       = 6'h02;
    localparam logic [5:0] c_OP_BEQ     = 6'h04;
    localparam logic [5:0] c_OP_BNE     = 6'h05;
    localparam logic [5:0] c_OP_IMM_LO  = 6'h08;
    localparam logic [5:0] c_OP_IMM_HI  = 6'h0F;
    localparam logic [5:0] c_OP_LW      = 6'h23;
    localparam logic [5:0] c_OP_SW      = 6'h2B;

    logic            warm_q, warm_d;
    logic            d_valid_q, d_valid_d;
    logic [XLEN-1:0] d_pc_q, d_pc_d;
    logic [31:0]     d_isn_q, d_isn_d;
    logic [NREG-1:0] busy_q, busy_d;
    logic            iss_valid_q, iss_valid_d;
    logic [XLEN-1:0] iss_pc_q, iss_pc_d;
    logic [5:0]      iss_op_q, iss_op_d;
    logic [4:0]      iss_rs_q, iss_rs_d;
    logic [4:0]      iss_rt_q, iss_rt_d;
    logic [4:0]      iss_dst_q, iss_dst_d;
    logic            iss_wen_q, iss_wen_d;
    logic [XLEN-1:0] iss_imm_q, iss_imm_d;
    logic            iss_illegal_q, iss_illegal_d;
    logic [31:0]     stall_cnt_q, stall_cnt_d;

    logic [5:0]      w_op;
    logic [4:0]      w_rs;
    logic [4:0]      w_rt;
    logic [4:0]      w_dst;
    logic            w_rd_rs;
    logic            w_rd_rt;
    logic            w_writes;
    logic            w_wen;
    logic            w_illegal;
    logic [XLEN-1:0] w_imm;
    logic            w_hazard;
    logic            w_issue;
    logic            w_stall;

    // Field decode of the held instruction.
    always_comb begin
        w_op      = d_isn_q[31:26];
        w_rs      = d_isn_q[25:21];
        w_rt      = d_isn_q[20:16];
        w_imm     = {{(XLEN-16){d_isn_q[15]}}, d_isn_q[15:0]};
        w_dst     = 5'd0;
        w_rd_rs   = 1'b0;
        w_rd_rt   = 1'b0;
        w_writes  = 1'b0;
        w_illegal = 1'b0;
        case (w_op) inside
            c_OP_RTYPE: begin
                w_rd_rs  = 1'b1;
                w_rd_rt  = 1'b1;
                w_writes = 1'b1;
                w_dst    = d_isn_q[15:11];
            end
            [c_OP_IMM_LO:c_OP_IMM_HI], c_OP_LW: begin
                w_rd_rs  = 1'b1;
                w_writes = 1'b1;
                w_dst    = w_rt;
            end
            c_OP_SW, c_OP_BEQ, c_OP_BNE: begin
                w_rd_rs = 1'b1;
                w_rd_rt = 1'b1;
            end
            c_OP_J: begin
                w_dst = 5'd0;
            end
            default: begin
                w_illegal = 1'b1;
            end
        endcase
        w_wen = w_writes && (w_dst != 5'd0);
    end

    always_comb begin
        w_hazard = d_valid_q && ((w_rd_rs && busy_q[w_rs]) ||
                                 (w_rd_rt && busy_q[w_rt]) ||
                                 (w_wen   && busy_q[w_dst]));
        w_issue  = d_valid_q && !w_hazard && (ex_ready || !iss_valid_q);
        w_stall  = d_valid_q && !w_issue;
        ctr      = w_stall ? c_CTR_STALL : c_CTR_RUN;
    end

    // Scoreboard: writeback clears first so a same-cycle issue set wins.
    always_comb begin
        busy_d = busy_q;
        if (wb_valid) begin
            busy_d[wb_rd] = 1'b0;
        end
        if (w_issue && w_wen) begin
            busy_d[w_dst] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_comb begin
        warm_d        = 1'b1;
        d_valid_d     = d_valid_q;
        d_pc_d        = d_pc_q;
        d_isn_d       = d_isn_q;
        iss_valid_d   = iss_valid_q;
        iss_pc_d      = iss_pc_q;
        iss_op_d      = iss_op_q;
        iss_rs_d      = iss_rs_q;
        iss_rt_d      = iss_rt_q;
        iss_dst_d     = iss_dst_q;
        iss_wen_d     = iss_wen_q;
        iss_imm_d     = iss_imm_q;
        iss_illegal_d = iss_illegal_q;
        stall_cnt_d   = stall_cnt_q + {31'd0, w_stall};
        if (!w_stall) begin
            d_valid_d = warm_q;
            d_pc_d    = fe_pc;
            d_isn_d   = fe_isn;
        end
        if (w_issue) begin
            iss_valid_d   = 1'b1;
            iss_pc_d      = d_pc_q;
            iss_op_d      = w_op;
            iss_rs_d      = w_rs;
            iss_rt_d      = w_rt;
            iss_dst_d     = w_dst;
            iss_wen_d     = w_wen;
            iss_imm_d     = w_imm;
            iss_illegal_d = w_illegal;
        end else if (ex_ready) begin
            iss_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            warm_q        <= 1'b0;
            d_valid_q     <= 1'b0;
            d_pc_q        <= '0;
            d_isn_q       <= '0;
            busy_q        <= '0;
            iss_valid_q   <= 1'b0;
            iss_pc_q      <= '0;
            iss_op_q      <= '0;
            iss_rs_q      <= '0;
            iss_rt_q      <= '0;
            iss_dst_q     <= '0;
            iss_wen_q     <= 1'b0;
            iss_imm_q     <= '0;
            iss_illegal_q <= 1'b0;
            stall_cnt_q   <= '0;
        end else begin
            warm_q        <= warm_d;
            d_valid_q     <= d_valid_d;
            d_pc_q        <= d_pc_d;
            d_isn_q       <= d_isn_d;
            busy_q        <= busy_d;
            iss_valid_q   <= iss_valid_d;
            iss_pc_q      <= iss_pc_d;
            iss_op_q      <= iss_op_d;
            iss_rs_q      <= iss_rs_d;
            iss_rt_q      <= iss_rt_d;
            iss_dst_q     <= iss_dst_d;
            iss_wen_q     <= iss_wen_d;
            iss_imm_q     <= iss_imm_d;
            iss_illegal_q <= iss_illegal_d;
            stall_cnt_q   <= stall_cnt_d;
        end
    end

    assign iss_valid   = iss_valid_q;
    assign iss_pc      = iss_pc_q;
    assign iss_op      = iss_op_q;
    assign iss_rs      = iss_rs_q;
    assign iss_rt      = iss_rt_q;
    assign iss_dst     = iss_dst_q;
    assign iss_wen     = iss_wen_q;
    assign iss_imm     = iss_imm_q;
    assign iss_illegal = iss_illegal_q;
    assign stall_cnt   = stall_cnt_q;

endmodule
`default_nettype wire

// File: doc/de_stage.md
# de_stage

Decode/issue stage that consumes the fetch stage's `pc`/instruction pair and returns the 2-bit fetch control (`ctr`, `2'b10` = stall). It latches one fetched instruction and decodes its fields. A 32-entry register scoreboard tracks RAW/WAW hazards. Hazard-free instructions issue to execute through a registered output with a ready handshake, and the stage stalls fetch whenever it cannot accept a new instruction.

## Interface

Parameters:
- `XLEN`, 32, data/address width.
- `NREG`, 32, architectural registers; scoreboard width.

Ports. Reset is synchronous and active-high, on `rst`, with the single clock `clk`.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: synchronous active-high reset.
- `fe_pc` input 32: address of `fe_isn`; the aligned pair is sampled on the same edge.
- `fe_isn` input 32: fetched instruction.
- `ctr` output 2: fetch control; `2'b10` = stall fetch, `2'b00` = run; other codes are never driven.
- `ex_ready` input 1: execute accepts the issue register this cycle.
- `wb_valid` input 1: writeback completing this cycle.
- `wb_rd` input 5: destination register being written back.
- `iss_valid` output 1: issue register holds a valid instruction.
- `iss_pc` output 32: pc of the issued instruction.
- `iss_op` output 6: opcode, `isn[31:26]`.
- `iss_rs` output 5: source register, `isn[25:21]`.
- `iss_rt` output 5: source register, `isn[20:16]`.
- `iss_dst` output 5: destination register.
- `iss_wen` output 1: instruction writes `iss_dst`.
- `iss_imm` output 32: `isn[15:0]`, sign-extended.
- `iss_illegal` output 1: unknown opcode; the instruction is issued as a NOP.
- `stall_cnt` output 32: count of cycles with `ctr == 2'b10`.

## Operation

Decode register `D` (`d_valid`, `d_pc`, `d_isn`) plus a warm-up flag `warm`.
- `warm` is 0 after reset and becomes 1 after the first clock edge out of reset.
- `D` loads `fe_pc`/`fe_isn` on every edge where `ctr != 2'b10`; `d_valid <= warm`.

Decode of `d_isn`:
- Opcode `6'h00` (R-type): reads rs, rt; writes rd (`isn[15:11]`).
- Opcodes `6'h08`–`6'h0F` (immediate ALU) and `6'h23` (LW): read rs; write rt.
- Opcode `6'h2B` (SW) and `6'h04`/`6'h05` (BEQ/BNE): read rs, rt; no write.
- Opcode `6'h02` (J): no reads, no write.
- Any other opcode: no reads, no write, `illegal = 1`.
- A write to r0 forces `wen = 0`.

Scoreboard `busy[NREG-1:0]`:
- `busy[0]` is always 0.
- `hazard` = `d_valid` and any of: a read source (rs or rt, only where the opcode reads it) is busy, or (`wen` and `busy[dst]`).
- Issue condition: `issue` = `d_valid && !hazard && (ex_ready || !iss_valid)`.
- On `issue`: `busy[dst] <= 1` if `wen`.
- On `wb_valid`: `busy[wb_rd] <= 0`.
- Same register set by issue and cleared by wb in the same cycle: the set wins.
- `wb_valid` for a register that is not busy is a no-op.

Issue register:
- On `issue`: load all `iss_*` fields from `D`; `iss_valid <= 1`.
- Else if `ex_ready`: `iss_valid <= 0`; the remaining fields hold.
- Else (`!ex_ready` and `iss_valid`): the whole register holds.

Fetch control:
- `ctr = (d_valid && !issue) ? 2'b10 : 2'b00`, combinational from registered state and `ex_ready`.
- While stalled, `D` holds and fetch does not advance.

`stall_cnt`: increments on each edge where `ctr == 2'b10`, wrapping modulo 2^32.

## Timing

Reset:
- Clears `D`, `warm`, `busy`, the issue register and `stall_cnt`.
- All outputs read 0 the cycle after the reset edge, and `ctr = 2'b00`.

Latency and throughput:
- Latency is 1 cycle from `D` load to `iss_valid`, absent hazards.
- Throughput is 1 instruction/cycle.

Scoreboard timing:
- The scoreboard has no bypass: a `wb_valid` clear becomes visible one cycle later.
- A dependent instruction therefore issues on the edge after the cycle in which `wb_valid` is asserted.

Reset mid-operation:
- Discards the held instruction and the pending busy bits.
- Writebacks arriving after reset only clear bits and are harmless.

## Test plan

- **Reset:** assert `rst` 2 cycles with random inputs. Required: all `iss_*` = 0, `busy` = 0, `ctr = 2'b00`, `stall_cnt = 0`. The first instruction after reset is not issued until `warm` is set.
- **Independent stream:** feed ADD r1,r2,r3 then ADD r4,r5,r6 with `ex_ready = 1`. Required: `iss_valid` on consecutive cycles, `ctr` stays `2'b00`, and `iss_dst` = 1 then 4.
- **RAW hazard:** ADD r3,r1,r2 then ADD r4,r3,r1; `wb_valid`/`wb_rd = 3` asserted 3 cycles after the first issue. Required:
  - `ctr = 2'b10` for 4 cycles.
  - The second instruction issues on the edge after the wb cycle.
  - `stall_cnt = 4`.
- **Backpressure:** hold `ex_ready = 0` for 3 cycles while `iss_valid = 1` and `D` is valid. Required: `iss_*` stable, `ctr = 2'b10` for 3 cycles, and issue on the first cycle `ex_ready = 1`.
- **Corner decodes:** ADDI r0,r1,-1, then opcode `6'h3F`, then ADD r5 issued while `wb_valid`/`wb_rd = 5` is asserted in the same cycle. Required:
  - ADDI: `iss_wen = 0`, `iss_imm = 32'hFFFF_FFFF`, and `busy[0]` stays 0.
  - Opcode `6'h3F`: `iss_illegal = 1`.
  - ADD r5: `busy[5]` remains 1.
- **Reset mid-stall:** during the RAW stall above, assert `rst`. Required: `ctr = 2'b00` and `busy = 0` the next cycle; a later `wb_valid` with `wb_rd = 3` causes no change.
